// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encodings,
// the default hold limit and a one-hot helper.
package rr_arbiter4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEFAULT_MAX_HOLD = 4;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 mux cell; s_i = 1 selects b_i.
module mux2 (
    input  logic a_i,
    input  logic b_i,
    input  logic s_i,
    output logic y_o
);

    assign y_o = s_i ? b_i : a_i;

endmodule

// File: rtl/mux4.sv
// Single-bit 4:1 mux cell assembled from three 2:1 cells.
module mux4 (
    input  logic       d0_i,
    input  logic       d1_i,
    input  logic       d2_i,
    input  logic       d3_i,
    input  logic [1:0] s_i,
    output logic       y_o
);

    logic lowPair;
    logic highPair;

    mux2 u_low  (.a_i(d0_i),    .b_i(d1_i),     .s_i(s_i[0]), .y_o(lowPair));
    mux2 u_high (.a_i(d2_i),    .b_i(d3_i),     .s_i(s_i[0]), .y_o(highPair));
    mux2 u_out  (.a_i(lowPair), .b_i(highPair), .s_i(s_i[1]), .y_o(y_o));

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping from 3 back to 0.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic       found;
    logic [1:0] cand;

    // The 2-bit candidate index wraps naturally, giving the 3->0 rotation.
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time per ownership
// and one idle turnaround cycle after every release.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int DW       = 8,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    state_t        state_q;
    logic [3:0]    gnt_q;
    logic [1:0]    sel_q;
    logic [1:0]    ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          holdDone;
    logic          pickAny;
    logic [1:0]    pickIdx;
    logic [DW-1:0] muxOut;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pickAny),
        .idx (pickIdx)
    );

    assign cnt_d    = cnt_q + CW'(1);
    assign holdDone = (cnt_q == CW'(MAX_HOLD));

    // Releases always land in IDLE, so a new grant needs one more edge: that
    // is the mandatory turnaround cycle. Non-owner request bits are never
    // consulted while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        state_q <= BUSY;
                        gnt_q   <= onehot4(pickIdx);
                        sel_q   <= pickIdx;
                        cnt_q   <= CW'(1);
                    end else begin
                        gnt_q   <= 4'b0000;
                    end
                end
                BUSY: begin
                    if (!req[sel_q] || holdDone) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        ptr_q   <= sel_q + 2'd1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    for (genvar b = 0; b < DW; b++) begin : g_bit
        mux4 u_mux (
            .d0_i (d0[b]),
            .d1_i (d1[b]),
            .d2_i (d2[b]),
            .d3_i (d3[b]),
            .s_i  (sel_q),
            .y_o  (muxOut[b])
        );
    end

    assign dout       = (state_q == BUSY) ? muxOut : '0;
    assign dout_valid = (state_q == BUSY) && req[sel_q];
    assign gnt        = gnt_q;
    assign sel        = sel_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: hand-computed grant sequences on a
// MAX_HOLD=4 instance plus a MAX_HOLD=1 instance sharing the same inputs.
module tb_rr_arbiter4;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [3:0]    gnt, gntOne;
    logic [1:0]    sel, selOne;
    logic [DW-1:0] dout, doutOne;
    logic          doutValid, doutValidOne;
    logic          monitorOn = 1'b0;
    int            checkCount = 0;
    int            errorCount = 0;

    rr_arbiter4 #(.DW(DW), .MAX_HOLD(4)) dut (
        .clk (clk), .rst (rst), .req (req),
        .d0 (d0), .d1 (d1), .d2 (d2), .d3 (d3),
        .gnt (gnt), .sel (sel), .dout (dout), .dout_valid (doutValid)
    );

    rr_arbiter4 #(.DW(DW), .MAX_HOLD(1)) dutOne (
        .clk (clk), .rst (rst), .req (req),
        .d0 (d0), .d1 (d1), .d2 (d2), .d3 (d3),
        .gnt (gntOne), .sel (selOne), .dout (doutOne), .dout_valid (doutValidOne)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a request pattern and let one rising edge sample it.
    task automatic applyStimulus(input logic [3:0] reqValue);
        req = reqValue;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Grant must be zero or one-hot on every cycle, for both instances.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            checkOutput("gntOne_onehot0", 32'($onehot0(gntOne)), 32'd1);
        end
    end

    initial begin
        int owners [5];
        owners = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req = 4'b0000;
        d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; d3 = 8'h44;
        @(posedge clk);
        #1;
        checkOutput("reset_gnt", gnt, 4'b0000);
        checkOutput("reset_sel", sel, 2'd0);
        checkOutput("reset_dout", dout, 8'h00);
        checkOutput("reset_valid", doutValid, 1'b0);
        rst = 1'b0;
        monitorOn = 1'b1;

        $display("[TB] single requester");
        applyStimulus(4'b0100);
        checkOutput("single_gnt_c1", gnt, 4'b0100);
        checkOutput("single_sel_c1", sel, 2'd2);
        checkOutput("single_dout_c1", dout, 8'h33);
        checkOutput("single_valid_c1", doutValid, 1'b1);
        applyStimulus(4'b0100);
        checkOutput("single_gnt_c2", gnt, 4'b0100);
        checkOutput("single_dout_c2", dout, 8'h33);
        applyStimulus(4'b0000);
        checkOutput("single_release_gnt", gnt, 4'b0000);
        checkOutput("single_release_dout", dout, 8'h00);
        checkOutput("single_release_valid", doutValid, 1'b0);
        applyStimulus(4'b1001);
        checkOutput("scan_from3_gnt", gnt, 4'b1000);
        checkOutput("scan_from3_dout", dout, 8'h44);
        applyStimulus(4'b0000);
        checkOutput("scan_from3_release", gnt, 4'b0000);

        $display("[TB] fairness with all requesters");
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus(4'b1111);
                checkOutput($sformatf("fair_gnt_k%0d_c%0d", k, c), gnt,
                            32'(4'b0001 << owners[k]));
                checkOutput($sformatf("fair_sel_k%0d_c%0d", k, c), sel, 32'(owners[k]));
            end
            if (k < 4) begin
                applyStimulus(4'b1111);
                checkOutput($sformatf("fair_turnaround_k%0d", k), gnt, 4'b0000);
            end
        end
        applyStimulus(4'b0000);
        checkOutput("fair_release", gnt, 4'b0000);

        $display("[TB] wrap and skip");
        applyStimulus(4'b0100);
        checkOutput("wrap_setup_gnt", gnt, 4'b0100);
        applyStimulus(4'b0000);
        checkOutput("wrap_setup_release", gnt, 4'b0000);
        applyStimulus(4'b0011);
        checkOutput("wrap_gnt", gnt, 4'b0001);
        checkOutput("wrap_dout", dout, 8'h11);
        applyStimulus(4'b0000);
        checkOutput("wrap_release", gnt, 4'b0000);

        $display("[TB] non-owner noise");
        applyStimulus(4'b0010);
        checkOutput("noise_gnt_c1", gnt, 4'b0010);
        applyStimulus(4'b1011);
        checkOutput("noise_gnt_c2", gnt, 4'b0010);
        checkOutput("noise_valid_c2", doutValid, 1'b1);
        applyStimulus(4'b0010);
        checkOutput("noise_gnt_c3", gnt, 4'b0010);
        applyStimulus(4'b1011);
        checkOutput("noise_gnt_c4", gnt, 4'b0010);
        checkOutput("noise_dout_c4", dout, 8'h22);
        applyStimulus(4'b0010);
        checkOutput("noise_hold_limit", gnt, 4'b0000);
        applyStimulus(4'b1011);
        checkOutput("noise_next_owner", gnt, 4'b1000);
        checkOutput("noise_next_sel", sel, 2'd3);
        applyStimulus(4'b0000);
        checkOutput("noise_release", gnt, 4'b0000);

        $display("[TB] reset mid-grant");
        applyStimulus(4'b0100);
        checkOutput("rstmid_gnt_c1", gnt, 4'b0100);
        applyStimulus(4'b0100);
        checkOutput("rstmid_gnt_c2", gnt, 4'b0100);
        pulseReset();
        checkOutput("rstmid_gnt", gnt, 4'b0000);
        checkOutput("rstmid_dout", dout, 8'h00);
        checkOutput("rstmid_valid", doutValid, 1'b0);
        applyStimulus(4'b1100);
        checkOutput("rstmid_regrant_gnt", gnt, 4'b0100);
        checkOutput("rstmid_regrant_sel", sel, 2'd2);
        checkOutput("rstmid_regrant_dout", dout, 8'h33);
        applyStimulus(4'b0000);
        checkOutput("rstmid_release", gnt, 4'b0000);

        $display("[TB] single-cycle hold limit");
        pulseReset();
        applyStimulus(4'b0001);
        checkOutput("hold1_gnt_c1", gntOne, 4'b0001);
        checkOutput("hold1_valid_c1", doutValidOne, 1'b1);
        checkOutput("hold4_gnt_c1", gnt, 4'b0001);
        applyStimulus(4'b0001);
        checkOutput("hold1_gnt_c2", gntOne, 4'b0000);
        checkOutput("hold1_dout_c2", doutOne, 8'h00);
        checkOutput("hold4_gnt_c2", gnt, 4'b0001);
        applyStimulus(4'b0001);
        checkOutput("hold1_gnt_c3", gntOne, 4'b0001);
        checkOutput("hold1_dout_c3", doutOne, 8'h11);
        applyStimulus(4'b0001);
        checkOutput("hold1_gnt_c4", gntOne, 4'b0000);
        applyStimulus(4'b0000);

        monitorOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
